// File: rtl/phase_detector.sv
// phase_detector: iterative CORDIC (vectoring) returning magnitude and phase of a Q0.7 (x, y) pair.
// Define PHASE_DETECTOR_GAIN_COMP_EN to scale magnitude_o by ~1/1.6468 (CORDIC gain compensation).
module phase_detector #(
  parameter int N_FRAC = 7,
  parameter int N_ITER = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic                     data_in_valid_strobe_i,
  output logic signed [N_FRAC:0]   magnitude_o,
  output logic signed [N_FRAC:0]   phase_o,
  output logic                     data_out_valid_strobe_o,
  output logic                     busy_o
);
  localparam int XW = N_FRAC + 5;
  localparam int ZW = N_FRAC + 2;
  localparam int EXT = XW - N_FRAC - 1;
  localparam logic [2:0] LAST = 3'(N_ITER - 1);
  localparam logic signed [ZW-1:0] HALF_PI = ZW'(1 << (N_FRAC - 1));
  localparam logic signed [XW-1:0] MAG_MAX = XW'((1 << N_FRAC) - 1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic zero;
  logic signed [XW-1:0] x, y, xe, ye, x_ld, y_ld, xs, ys, x_nx, y_nx, xg;
  logic signed [ZW-1:0] z, z_ld, z_nx, at;
  logic signed [N_FRAC:0] mag;
  assign busy_o = state != IDLE;
  always_comb begin
    xe = {{EXT{x_i[N_FRAC]}}, x_i};
    ye = {{EXT{y_i[N_FRAC]}}, y_i};
    x_ld = !xe[XW-1] ? xe : (!ye[XW-1] ? ye : -ye);
    y_ld = !xe[XW-1] ? ye : (!ye[XW-1] ? -xe : xe);
    z_ld = !xe[XW-1] ? '0 : (!ye[XW-1] ? HALF_PI : -HALF_PI);
  end
  // round(atan(2^-i) * 128 / pi)
  always_comb begin
    at = cnt == 3'd0 ? 9'sd32 :
         cnt == 3'd1 ? 9'sd19 :
         cnt == 3'd2 ? 9'sd10 :
         cnt == 3'd3 ? 9'sd5  :
         cnt == 3'd4 ? 9'sd3  : 9'sd1;
    xs = x >>> cnt;
    ys = y >>> cnt;
    x_nx = y[XW-1] ? x - ys : x + ys;
    y_nx = y[XW-1] ? y + xs : y - xs;
    z_nx = y[XW-1] ? z - at : z + at;
  end
  always_comb begin
`ifdef PHASE_DETECTOR_GAIN_COMP_EN
    xg = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
`else
    xg = x;
`endif
    mag = xg[XW-1] ? '0 : (xg > MAG_MAX ? MAG_MAX[N_FRAC:0] : xg[N_FRAC:0]);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (data_in_valid_strobe_i ? ITER : IDLE) :
               state == ITER ? (cnt == LAST ? DONE : ITER) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      zero <= 1'b0;
      x <= '0;
      y <= '0;
      z <= '0;
      magnitude_o <= '0;
      phase_o <= '0;
      data_out_valid_strobe_o <= 1'b0;
    end else begin
      state <= state_nx;
      data_out_valid_strobe_o <= state == DONE;
      if (state == IDLE && data_in_valid_strobe_i) begin
        x <= x_ld;
        y <= y_ld;
        z <= z_ld;
        cnt <= '0;
        zero <= x_i == '0 && y_i == '0;
      end
      if (state == ITER) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        cnt <= cnt == LAST ? cnt : cnt + 3'd1;
      end
      if (state == DONE) begin
        magnitude_o <= zero ? '0 : mag;
        phase_o <= zero ? '0 : z[N_FRAC:0];
      end
    end
  end
endmodule
